// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  localparam int RX_OVERSAMPLE_DEFAULT = 16;
endpackage

// File: rtl/gh_shift_reg_se_sl.sv
// gh_shift_reg_se_sl: shift-enabled serial-in register, new bits enter at the MSB so the first bit ends at the LSB
module gh_shift_reg_se_sl #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            srst,
  input  logic            se,
  input  logic            d,
  output logic [SIZE-1:0] q
);
  // shift right on each enable; synchronous clear wins over shifting
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (srst) q <= '0;
    else if (se) q <= {d, q[SIZE-1:1]};
endmodule

// File: rtl/uart_rx_seq.sv
// uart_rx_seq: oversampling UART receive sequencer with parity and stop-bit checking
module uart_rx_seq
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = RX_OVERSAMPLE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 srst,
  input  logic                 brc,
  input  logic                 sin,
  input  logic                 parity_en,
  input  logic                 parity_even,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rdy,
  output logic                 pe,
  output logic                 fe,
  output logic                 busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  rx_state_t state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic acc, acc_n, perr, perr_n;
  logic s1, sin_s, se, qual, done;
  logic [DATA_BITS-1:0] q;
  assign busy = state != IDLE;
  gh_shift_reg_se_sl #(.SIZE(DATA_BITS)) u_sr (
    .clk (clk),
    .rst (rst),
    .srst(srst | qual),
    .se  (se),
    .d   (sin_s),
    .q   (q)
  );
  // two-flop synchroniser for the raw line, idles high
  always_ff @(posedge clk or posedge rst)
    if (rst) {s1, sin_s} <= 2'b11;
    else if (srst) {s1, sin_s} <= 2'b11;
    else {s1, sin_s} <= {sin, s1};
  // FSM state, tick/bit counters and parity bookkeeping
  always_ff @(posedge clk or posedge rst)
    if (rst || srst) begin
      state <= IDLE;
      tcnt  <= '0;
      bcnt  <= '0;
      acc   <= 1'b0;
      perr  <= 1'b0;
    end else begin
      state <= state_n;
      tcnt  <= tcnt_n;
      bcnt  <= bcnt_n;
      acc   <= acc_n;
      perr  <= perr_n;
    end
  // next state; every state advances only on a brc tick, sampling mid-bit
  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    bcnt_n  = bcnt;
    acc_n   = acc;
    perr_n  = perr;
    se      = 1'b0;
    qual    = 1'b0;
    done    = 1'b0;
    if (brc) begin
      tcnt_n = tcnt + 1'b1;
      case (state)
        IDLE: begin
          tcnt_n  = '0;
          state_n = sin_s ? IDLE : START;
        end
        START: if (tcnt == T_MID) begin
          tcnt_n  = '0;
          bcnt_n  = '0;
          acc_n   = 1'b0;
          perr_n  = 1'b0;
          qual    = ~sin_s;
          state_n = sin_s ? IDLE : DATA;
        end
        DATA: if (tcnt == T_END) begin
          tcnt_n = '0;
          se     = 1'b1;
          acc_n  = acc ^ sin_s;
          bcnt_n = bcnt + 1'b1;
          if (bcnt == B_LAST) state_n = parity_en ? PARITY : STOP;
        end
        PARITY: if (tcnt == T_END) begin
          tcnt_n  = '0;
          perr_n  = acc ^ sin_s ^ ~parity_even;
          state_n = STOP;
        end
        STOP: if (tcnt == T_END) begin
          tcnt_n  = '0;
          done    = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  // output word and status, updated together with the one-cycle ready pulse
  always_ff @(posedge clk or posedge rst)
    if (rst || srst) begin
      dout <= '0;
      rdy  <= 1'b0;
      pe   <= 1'b0;
      fe   <= 1'b0;
    end else begin
      rdy <= done;
      if (done) begin
        dout <= q;
        fe   <= ~sin_s;
        pe   <= parity_en & perr;
      end
    end
endmodule

// File: tb/tb_uart_rx_seq.sv
// tb_uart_rx_seq: directed frames into 8-bit and 5-bit receivers with logged ready results
module tb_uart_rx_seq;
  localparam int OS = 16;
  logic clk = 1'b0, rst = 1'b1, srst = 1'b0, brc = 1'b0;
  logic sin8 = 1'b1, sin5 = 1'b1, par_en = 1'b0, par_even = 1'b0;
  logic [7:0] dout8;
  logic [4:0] dout5;
  logic rdy8, pe8, fe8, busy8, rdy5, pe5, fe5, busy5;
  logic [9:0] log8[$];
  logic [9:0] log5[$];
  int errors = 0, checks = 0;
  uart_rx_seq #(.DATA_BITS(8), .OVERSAMPLE(OS)) u8 (
    .clk(clk), .rst(rst), .srst(srst), .brc(brc), .sin(sin8),
    .parity_en(par_en), .parity_even(par_even),
    .dout(dout8), .rdy(rdy8), .pe(pe8), .fe(fe8), .busy(busy8)
  );
  uart_rx_seq #(.DATA_BITS(5), .OVERSAMPLE(OS)) u5 (
    .clk(clk), .rst(rst), .srst(srst), .brc(brc), .sin(sin5),
    .parity_en(par_en), .parity_even(par_even),
    .dout(dout5), .rdy(rdy5), .pe(pe5), .fe(fe5), .busy(busy5)
  );
  always #5 clk = ~clk;
  always @(negedge clk) brc = ~brc;
  always @(negedge clk) begin
    if (rdy8) log8.push_back({fe8, pe8, dout8});
    if (rdy5) log5.push_back({3'b0, fe5, pe5, dout5});
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!brc) @(posedge clk);
    end
    @(negedge clk);
  endtask
  task automatic drive(input bit five, input logic v);
    if (five) sin5 = v;
    else sin8 = v;
  endtask
  task automatic send(input bit five, input int nb, input logic [7:0] data,
                      input bit pen, input logic pbit, input logic stop);
    drive(five, 1'b0);
    ticks(OS);
    for (int i = 0; i < nb; i++) begin
      drive(five, data[i]);
      ticks(OS);
    end
    if (pen) begin
      drive(five, pbit);
      ticks(OS);
    end
    drive(five, stop);
    ticks(stop ? OS : OS / 2 + 2);
    if (!stop) begin
      drive(five, 1'b1);
      ticks(OS);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ticks(2);
    chk("rst_dout", dout8, 0);
    chk("rst_rdy", rdy8, 0);
    chk("rst_pe", pe8, 0);
    chk("rst_fe", fe8, 0);
    chk("rst_busy", busy8, 0);
    send(0, 8, 8'h55, 0, 0, 1);
    send(0, 8, 8'hA3, 0, 0, 1);
    chk("b2b_count", log8.size(), 2);
    chk("b2b_w0", log8[0], 10'h055);
    chk("b2b_w1", log8[1], 10'h0A3);
    par_en = 1'b1;
    par_even = 1'b1;
    ticks(4);
    send(0, 8, 8'hA7, 1, 1, 1);
    chk("even_ok", log8[2], 10'h0A7);
    send(0, 8, 8'hA7, 1, 0, 1);
    chk("even_bad", log8[3], 10'h1A7);
    par_even = 1'b0;
    ticks(4);
    send(0, 8, 8'h00, 1, 1, 1);
    chk("odd_ok", log8[4], 10'h000);
    par_en = 1'b0;
    ticks(4);
    send(0, 8, 8'h3C, 0, 0, 0);
    chk("fe_count", log8.size(), 6);
    chk("fe_word", log8[5], 10'h23C);
    chk("fe_busy", busy8, 0);
    sin8 = 1'b0;
    ticks(3);
    chk("glitch_busy", busy8, 1);
    ticks(OS / 4 - 3);
    sin8 = 1'b1;
    ticks(OS);
    chk("glitch_idle", busy8, 0);
    chk("glitch_count", log8.size(), 6);
    chk("glitch_dout", dout8, 8'h3C);
    send(1, 5, 8'h1B, 0, 0, 1);
    chk("w5_count", log5.size(), 1);
    chk("w5_word", log5[0], 10'h01B);
    chk("w5_dout", dout5, 5'h1B);
    sin8 = 1'b0;
    ticks(OS);
    for (int i = 0; i < 3; i++) begin
      sin8 = 1'b1;
      ticks(OS);
    end
    chk("mid_busy_pre", busy8, 1);
    rst = 1'b1;
    #1;
    chk("mid_dout", dout8, 0);
    chk("mid_busy", busy8, 0);
    chk("mid_pe_fe", {pe8, fe8}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ticks(OS * 2);
    chk("mid_no_rdy", log8.size(), 6);
    send(0, 8, 8'h81, 0, 0, 1);
    chk("after_count", log8.size(), 7);
    chk("after_word", log8[6], 10'h081);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    #1;
    chk("srst_dout", dout8, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
